// File: rtl/fetch_pc_unit.sv
// Fetch-side PC generator: drives the IF PC toward the branch history table,
// carries PC and prediction flag through ID to EX, resolves redirects, and
// keeps saturating branch / mispredict statistics.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             stall,
    input  logic             bht_hit,
    input  logic [31:0]      bht_target,
    input  logic             pcclear,
    input  logic             ex_isjmp,
    input  logic [31:0]      ex_target,
    output logic [31:0]      if_pc,
    output logic [31:0]      id_pc,
    output logic [31:0]      ex_pc,
    output logic             ex_pcchoose,
    output logic             ex_valid,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned PC_W     = 32;
    localparam logic [PC_W-1:0] PC_MASK  = 32'hFFFF_FFFC;
    localparam logic [PC_W-1:0] PC_STEP  = 32'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]  if_pc_q, if_pc_d;
    logic [PC_W-1:0]  id_pc_q, id_pc_d;
    logic             id_valid_q, id_valid_d;
    logic             id_choose_q, id_choose_d;
    logic [PC_W-1:0]  ex_pc_q, ex_pc_d;
    logic             ex_valid_q, ex_valid_d;
    logic             ex_choose_q, ex_choose_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic             redir;
    logic             resolved;
    logic [PC_W-1:0]  redirect_pc;

    // Redirect qualification and corrected PC for either mispredict direction
    always_comb begin
        redir       = pcclear & ex_valid_q;
        resolved    = ex_valid_q & ~stall & (ex_isjmp | ex_choose_q);
        redirect_pc = (ex_isjmp ? ex_target : (ex_pc_q + PC_STEP)) & PC_MASK;
    end

    // Next-state for PC, the ID/EX prediction pipeline and the counters
    always_comb begin
        if_pc_d          = if_pc_q;
        id_pc_d          = id_pc_q;
        id_valid_d       = id_valid_q;
        id_choose_d      = id_choose_q;
        ex_pc_d          = ex_pc_q;
        ex_valid_d       = ex_valid_q;
        ex_choose_d      = ex_choose_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        if (redir) begin
            // Killed slots keep their stale PCs; only the valid bits matter.
            if_pc_d     = redirect_pc;
            id_valid_d  = 1'b0;
            id_choose_d = 1'b0;
            ex_valid_d  = 1'b0;
            ex_choose_d = 1'b0;
        end else if (!stall) begin
            if_pc_d     = bht_hit ? (bht_target & PC_MASK) : ((if_pc_q + PC_STEP) & PC_MASK);
            id_pc_d     = if_pc_q;
            id_valid_d  = 1'b1;
            id_choose_d = bht_hit;
            ex_pc_d     = id_pc_q;
            ex_valid_d  = id_valid_q;
            ex_choose_d = id_valid_q & id_choose_q;
        end

        if (resolved && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (redir && (mispredict_cnt_q != CNT_MAX)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            if_pc_q          <= RESET_PC & PC_MASK;
            id_pc_q          <= '0;
            id_valid_q       <= 1'b0;
            id_choose_q      <= 1'b0;
            ex_pc_q          <= '0;
            ex_valid_q       <= 1'b0;
            ex_choose_q      <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if_pc_q          <= if_pc_d;
            id_pc_q          <= id_pc_d;
            id_valid_q       <= id_valid_d;
            id_choose_q      <= id_choose_d;
            ex_pc_q          <= ex_pc_d;
            ex_valid_q       <= ex_valid_d;
            ex_choose_q      <= ex_choose_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign if_pc          = if_pc_q;
    assign id_pc          = id_pc_q;
    assign ex_pc          = ex_pc_q;
    assign ex_pcchoose    = ex_choose_q;
    assign ex_valid       = ex_valid_q;
    assign flush          = redir;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side PC generator and prediction carrier, directly upstream of and feeding the branch history table.
- Drives the IF-stage PC that the table looks up, and consumes its hit/target prediction and its pcclear redirect request.
- Carries the per-instruction PC and prediction flag through ID to EX, where they become the table's Expc/Expcchoose update inputs.
- Computes the corrected PC on a misprediction and keeps saturating branch and mispredict statistics counters.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
CNT_W, 16, width of the statistics counters

Ports:
clk_sys  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
stall  in  1  pipeline hold from hazard unit
bht_hit  in  1  table prediction for current if_pc (IFpcchoose)
bht_target  in  32  predicted target (IFnpc)
pcclear  in  1  table redirect request (misprediction resolved in EX)
ex_isjmp  in  1  EX datapath: branch/jump actually taken
ex_target  in  32  EX datapath: computed taken target (Exnpc)
if_pc  out  32  current fetch PC (IFpc)
id_pc  out  32  PC of instruction in ID
ex_pc  out  32  PC of instruction in EX (Expc)
ex_pcchoose  out  1  prediction flag of EX instruction (Expcchoose)
ex_valid  out  1  EX slot holds a live instruction
flush  out  1  kill IF/ID and ID/EX latches this cycle
branch_cnt  out  CNT_W  resolved control-flow instructions
mispredict_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset (async, rst=1), all outputs immediately:
  - if_pc=RESET_PC.
  - id_pc=ex_pc=0; id_valid/ex_valid=0; id_choose/ex_pcchoose=0.
  - branch_cnt=mispredict_cnt=0.
  - Reset mid-operation discards all in-flight state and counts.
- Qualified redirect: redir = pcclear & ex_valid. pcclear with ex_valid=0 is ignored entirely (no PC change, no flush, no count).
- flush = redir (combinational).
- redirect_pc = ex_isjmp ? ex_target : ex_pc+4. Covers both mispredict cases:
  - predicted-not-taken but taken: go to ex_target.
  - predicted-taken but not taken: fall through to ex_pc+4.
- if_pc next value, priority high to low:
  - redir: redirect_pc.
  - stall: hold.
  - bht_hit: bht_target.
  - otherwise: if_pc+4.
- PC arithmetic:
  - Modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - Bits [1:0] of every loaded PC are forced to 00.
- Prediction pipeline, 2 stages (IF->ID->EX), shifted on the same posedge as the PC:
  - redir: id_valid=0, ex_valid=0, id_choose=0, ex_pcchoose=0. PCs of killed slots are don't-care. The redirected PC enters IF next cycle.
  - stall (no redir): all ID/EX registers hold.
  - Otherwise: ID<=(1, if_pc, bht_hit); EX<=(id_valid, id_pc, id_choose).
  - ex_pcchoose is always forced to 0 whenever ex_valid=0.
- Redirect vs. stall: on simultaneous redir and stall, redir wins.
- Latency:
  - Prediction flag presented with if_pc reaches ex_pcchoose 2 unstalled cycles later.
  - Misprediction penalty is 2 killed slots.
- Timing contract with the table:
  - The table samples if_pc and the EX signals on negedge and updates bht_hit/bht_target/pcclear before the following posedge.
  - This block samples them only on posedge.
- Counters:
  - resolved = ex_valid & ~stall & (ex_isjmp | ex_pcchoose).
  - branch_cnt += 1 when resolved; mispredict_cnt += 1 when redir.
  - Both saturate at 2^CW-1 (no wrap).
  - Counters are not affected by stall except via the resolved qualifier.

Test Plan:
- Sequential fetch: release reset with RESET_PC=0, bht_hit=0, no stall -> if_pc 0,4,8,C on successive posedges; ex_valid rises on the 3rd edge with ex_pc=0, ex_pcchoose=0.
- Predicted taken: bht_hit=1, bht_target=32'h100 while if_pc=8 -> next if_pc=0x100; two cycles later ex_pc=8, ex_pcchoose=1; ex_isjmp=1 with pcclear=0 -> branch_cnt=1, mispredict_cnt=0.
- Mispredict not-taken: ex_pc=0x20, ex_pcchoose=0, ex_isjmp=1, ex_target=0x80, pcclear=1 -> flush=1 same cycle; next if_pc=0x80, id_valid=ex_valid=0; mispredict_cnt increments. Then with ex_pcchoose=1, ex_isjmp=0, ex_pc=0x40, pcclear=1 -> next if_pc=0x44.
- Stall and redirect: stall=1 for 3 cycles -> if_pc, id_pc, ex_pc frozen and counters unchanged; stall=1 with a valid pcclear -> redirect taken, slots killed. pcclear=1 with ex_valid=0 -> no effect.
- Wrap and saturation: bht_target=32'hFFFF_FFFE with hit -> if_pc=FFFF_FFFC, then 0. CNT_W=4 with 20 redirects -> mispredict_cnt holds 15.
- Async reset mid-stream: assert rst between clock edges during a redirect -> outputs return to reset values immediately; first edge after release fetches RESET_PC.
